// File: rtl/dmb_ctl_pkg.sv
// rtl/dmb_ctl_pkg.sv - shared DMB readout control types, source indices and priority order
package dmb_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_READ   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } sched_state_t;

    localparam int NUM_SRC   = 7;
    localparam int SRC_ALCT  = 7;
    localparam int SRC_TMB   = 6;
    localparam int SRC_CFEB1 = 1;
    localparam int SRC_CFEB2 = 2;
    localparam int SRC_CFEB3 = 3;
    localparam int SRC_CFEB4 = 4;
    localparam int SRC_CFEB5 = 5;

    // Source indices from highest to lowest priority, highest in the top field.
    localparam logic [20:0] PRIO_ORDER = {3'(SRC_ALCT), 3'(SRC_TMB), 3'(SRC_CFEB1),
                                          3'(SRC_CFEB2), 3'(SRC_CFEB3), 3'(SRC_CFEB4),
                                          3'(SRC_CFEB5)};

    // Source index holding priority rank r (0 = highest).
    function automatic logic [2:0] prio_src(input int rank);
        return PRIO_ORDER[20 - 3*rank -: 3];
    endfunction

endpackage

// File: rtl/cbnce.sv
// rtl/cbnce.sv - binary counter with clock enable and sync clear, optional triple redundancy
module cbnce #(
    parameter int W   = 12,
    parameter int TMR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         clr,
    output logic [W-1:0] q
);

    generate
        if (TMR != 0) begin : g_tmr
            logic [W-1:0] c0, c1, c2, voted;

            assign voted = (c0 & c1) | (c0 & c2) | (c1 & c2);
            assign q     = voted;

            // Each copy reloads from the vote, so a single upset is scrubbed on the next edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c0 <= '0;
                    c1 <= '0;
                    c2 <= '0;
                end else if (clr) begin
                    c0 <= '0;
                    c1 <= '0;
                    c2 <= '0;
                end else if (ce) begin
                    c0 <= voted + 1'b1;
                    c1 <= voted + 1'b1;
                    c2 <= voted + 1'b1;
                end else begin
                    c0 <= voted;
                    c1 <= voted;
                    c2 <= voted;
                end
            end
        end else begin : g_single
            // Plain counter.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (clr) begin
                    q <= '0;
                end else if (ce) begin
                    q <= q + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/prio_enc7.sv
// rtl/prio_enc7.sv - fixed-priority one-hot picker over the seven DMB sources
module prio_enc7
    import dmb_ctl_pkg::*;
(
    input  logic [7:1] req,
    output logic [7:1] grant
);

    logic found;

    // Walk the priority order and keep the first requesting source.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int r = 0; r < NUM_SRC; r++) begin
            if (!found && req[prio_src(r)]) begin
                grant[prio_src(r)] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cms_readout_sched.sv
// rtl/cms_readout_sched.sv - per-event DMB source readout scheduler with grant watchdog
module cms_readout_sched
    import dmb_ctl_pkg::*;
#(
    parameter int TMO_W = 12,
    parameter int TMR   = 0
) (
    input  logic       CLKCMS,
    input  logic       pop_rst,
    input  logic       START,
    input  logic [7:1] ACT,
    input  logic [7:1] KILL,
    input  logic [7:1] RDY,
    input  logic       LAST,
    input  logic       HOLD,
    output logic [7:1] GRANT,
    output logic       RDEN,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:1] NOEND,
    output logic [7:1] NODATA
);

    // The counter leaves READ on the edge it first reaches the MSB, so an exact
    // compare against the MSB-only value is the MSB test.
    localparam logic [TMO_W-1:0] TMO_LIMIT = {1'b1, {(TMO_W-1){1'b0}}};

    sched_state_t     state, state_nxt;
    logic [7:1]       pend;
    logic [7:1]       pick;
    logic             seen;
    logic [TMO_W-1:0] cnt;
    logic             cnt_ce, cnt_clr;
    logic             tmo;
    logic             src_rdy;
    logic             rden_c;

    prio_enc7 u_prio (
        .req   (pend),
        .grant (pick)
    );

    cbnce #(.W(TMO_W), .TMR(TMR)) u_wdog (
        .clk (CLKCMS),
        .rst (pop_rst),
        .ce  (cnt_ce),
        .clr (cnt_clr),
        .q   (cnt)
    );

    assign src_rdy = |(GRANT & RDY);
    assign tmo     = (cnt == TMO_LIMIT);
    assign RDEN    = rden_c;
    assign BUSY    = (state != ST_IDLE);
    assign DONE    = (state == ST_FINISH);

    // State register.
    always_ff @(posedge CLKCMS or posedge pop_rst) begin
        if (pop_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, read strobe and watchdog control.
    always_comb begin
        state_nxt = state;
        rden_c    = 1'b0;
        cnt_ce    = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                cnt_clr   = 1'b1;
                state_nxt = (pend == '0) ? ST_FINISH : ST_READ;
            end
            ST_READ: begin
                rden_c = src_rdy & ~HOLD;
                cnt_ce = ~HOLD;
                if ((rden_c & LAST) | tmo) state_nxt = ST_GAP;
            end
            ST_GAP:    state_nxt = ST_SELECT;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Event datapath: pending mask, current grant, ready-seen flag and error flags.
    always_ff @(posedge CLKCMS or posedge pop_rst) begin
        if (pop_rst) begin
            pend   <= '0;
            GRANT  <= '0;
            seen   <= 1'b0;
            NOEND  <= '0;
            NODATA <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        pend   <= ACT & ~KILL;
                        NOEND  <= '0;
                        NODATA <= '0;
                    end
                end
                ST_SELECT: begin
                    seen <= 1'b0;
                    if (pend != '0) GRANT <= pick;
                end
                ST_READ: begin
                    if (src_rdy) seen <= 1'b1;
                    if (rden_c && LAST) begin
                        pend  <= pend & ~GRANT;
                        GRANT <= '0;
                    end else if (tmo) begin
                        if (seen) NOEND  <= NOEND | GRANT;
                        else      NODATA <= NODATA | GRANT;
                        pend  <= pend & ~GRANT;
                        GRANT <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cms_readout_sched.sv
// tb/tb_cms_readout_sched.sv - scoreboard bench for cms_readout_sched
module tb_cms_readout_sched;

    localparam int TMO_W = 4;

    logic       CLKCMS = 1'b0;
    logic       pop_rst;
    logic       START;
    logic [7:1] ACT, KILL, RDY;
    logic       LAST, HOLD;
    logic [7:1] GRANT;
    logic       RDEN, BUSY, DONE;
    logic [7:1] NOEND, NODATA;

    cms_readout_sched #(.TMO_W(TMO_W), .TMR(0)) dut (
        .CLKCMS (CLKCMS),
        .pop_rst(pop_rst),
        .START  (START),
        .ACT    (ACT),
        .KILL   (KILL),
        .RDY    (RDY),
        .LAST   (LAST),
        .HOLD   (HOLD),
        .GRANT  (GRANT),
        .RDEN   (RDEN),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .NOEND  (NOEND),
        .NODATA (NODATA)
    );

    always #5 CLKCMS = ~CLKCMS;

    typedef struct {
        logic [7:1] grant;
        int         nrden;
    } gexp_t;

    typedef struct {
        logic [7:1] noend;
        logic [7:1] nodata;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    int         last_rden[8];
    int         last_cyc[8];
    int         hold_start, hold_len;
    logic [7:1] mid_bit;
    int         ccnt, rcnt;
    logic [7:1] drv_prev;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_g(input logic [7:1] g, input int n);
        gexp_t e;
        e.grant = g;
        e.nrden = n;
        gq.push_back(e);
    endtask

    task automatic push_d(input logic [7:1] ne, input logic [7:1] nd);
        dexp_t e;
        e.noend  = ne;
        e.nodata = nd;
        dq.push_back(e);
    endtask

    task automatic cfg_clear();
        for (int i = 0; i < 8; i++) begin
            last_rden[i] = 0;
            last_cyc[i]  = 0;
        end
        hold_start = 0;
        hold_len   = 0;
        mid_bit    = '0;
        RDY        = '0;
    endtask

    // One clock of source-side behaviour: HOLD window, mid-event START, LAST on the chosen beat.
    task automatic step();
        int idx;
        @(posedge CLKCMS);
        #1;
        START = 1'b0;
        LAST  = 1'b0;
        if (GRANT != drv_prev) begin
            ccnt = 0;
            rcnt = 0;
        end
        drv_prev = GRANT;
        HOLD = (hold_len > 0) && (GRANT != '0) && (ccnt >= hold_start) && (ccnt < hold_start + hold_len);
        if (mid_bit != '0 && GRANT == mid_bit && ccnt == 0) begin
            START = 1'b1;
            ACT   = 7'h7f;
        end
        #1;
        if (GRANT != '0) begin
            idx = 0;
            for (int i = 1; i <= 7; i++) if (GRANT[i]) idx = i;
            if (HOLD) check("rden_under_hold", RDEN, 0);
            if (RDEN && ((last_rden[idx] != 0 && rcnt == last_rden[idx] - 1) ||
                         (last_cyc[idx] != 0 && ccnt == last_cyc[idx] - 1)))
                LAST = 1'b1;
            if (RDEN) rcnt++;
            ccnt++;
        end
    endtask

    task automatic start_event(input logic [7:1] act, input logic [7:1] kill);
        ACT   = act;
        KILL  = kill;
        START = 1'b1;
        step();
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            step();
            k++;
        end
        check("done_seen", done_cnt - d0, 1);
    endtask

    task automatic empty_event(input string tag, input logic [7:1] act, input logic [7:1] kill);
        push_d('0, '0);
        start_event(act, kill);
        check({tag, "_busy_select"}, BUSY, 1);
        check({tag, "_done_select"}, DONE, 0);
        step();
        check({tag, "_done_finish"}, DONE, 1);
        check({tag, "_busy_finish"}, BUSY, 1);
        check({tag, "_grant_none"}, GRANT, 0);
        step();
        check({tag, "_done_idle"}, DONE, 0);
        check({tag, "_busy_idle"}, BUSY, 0);
    endtask

    // Monitor: pops expected grants and end-of-event records whenever the DUT presents them.
    initial begin : monitor
        logic [7:1] prev_g;
        gexp_t      cur;
        dexp_t      de;
        logic       cur_valid;
        int         mon_rden;
        prev_g    = '0;
        cur_valid = 1'b0;
        mon_rden  = 0;
        forever begin
            @(negedge CLKCMS);
            if (pop_rst) begin
                prev_g    = '0;
                cur_valid = 1'b0;
                mon_rden  = 0;
            end else begin
                check("grant_onehot0", 32'($onehot0(GRANT)), 1);
                if (GRANT == '0) check("rden_without_grant", RDEN, 0);
                if (prev_g == '0 && GRANT != '0) begin
                    mon_rden = 0;
                    if (gq.size() == 0) begin
                        check("grant_unexpected", GRANT, 0);
                    end else begin
                        cur = gq.pop_front();
                        cur_valid = 1'b1;
                        check("grant_seq", GRANT, cur.grant);
                    end
                end
                if (GRANT != '0 && RDEN) mon_rden++;
                if (prev_g != '0 && GRANT == '0 && cur_valid) begin
                    check("rden_count", mon_rden, cur.nrden);
                    cur_valid = 1'b0;
                end
                if (DONE) begin
                    done_cnt++;
                    if (dq.size() == 0) begin
                        check("done_unexpected", DONE, 0);
                    end else begin
                        de = dq.pop_front();
                        check("done_noend", NOEND, de.noend);
                        check("done_nodata", NODATA, de.nodata);
                    end
                end
                prev_g = GRANT;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        int k;
        pop_rst  = 1'b0;
        START    = 1'b0;
        ACT      = '0;
        KILL     = '0;
        RDY      = '0;
        LAST     = 1'b0;
        HOLD     = 1'b0;
        drv_prev = '0;
        ccnt     = 0;
        rcnt     = 0;
        cfg_clear();
        #2 pop_rst = 1'b1;
        @(posedge CLKCMS);
        @(posedge CLKCMS);
        #1;
        check("rst_grant", GRANT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_rden", RDEN, 0);
        check("rst_noend", NOEND, 0);
        check("rst_nodata", NODATA, 0);
        pop_rst = 1'b0;

        // 1: normal priority order, LAST on the 3rd read of each grant
        cfg_clear();
        RDY = 7'h7f;
        last_rden[7] = 3; last_rden[6] = 3; last_rden[1] = 3; last_rden[2] = 3;
        push_g(7'h40, 3); push_g(7'h20, 3); push_g(7'h01, 3); push_g(7'h02, 3);
        push_d('0, '0);
        start_event(7'b1100011, '0);
        check("t1_busy", BUSY, 1);
        step();
        check("t1_grant_latency", GRANT, 7'h40);
        ACT  = '0;
        KILL = 7'h7f;
        wait_done(200);

        // 2: killed source and empty mask
        cfg_clear();
        empty_event("t2_kill", 7'h04, 7'h04);
        empty_event("t2_empty", 7'h00, 7'h00);

        // 3: timeout classes, flags hold until the next START
        cfg_clear();
        RDY = 7'h01;
        push_g(7'h01, 9); push_g(7'h02, 0);
        push_d(7'h01, 7'h02);
        start_event(7'h03, '0);
        wait_done(200);
        repeat (3) step();
        check("t3_noend_hold", NOEND, 7'h01);
        check("t3_nodata_hold", NODATA, 7'h02);
        push_d('0, '0);
        start_event(7'h00, '0);
        check("t3_noend_clear", NOEND, 0);
        check("t3_nodata_clear", NODATA, 0);
        step();
        step();

        // 4: HOLD for 20 cycles freezes reads and watchdog
        cfg_clear();
        RDY = 7'h01;
        last_rden[1] = 3;
        hold_start = 2;
        hold_len   = 20;
        push_g(7'h01, 3);
        push_d('0, '0);
        start_event(7'h01, '0);
        wait_done(200);

        // 5: LAST on the timeout edge wins
        cfg_clear();
        RDY = 7'h01;
        last_cyc[1] = 9;
        push_g(7'h01, 9);
        push_d('0, '0);
        start_event(7'h01, '0);
        wait_done(200);

        // 6: asynchronous reset while TMB is granted
        cfg_clear();
        RDY = 7'h7f;
        last_rden[7] = 2;
        push_g(7'h40, 2); push_g(7'h20, 0);
        start_event(7'h60, '0);
        k = 0;
        while (GRANT != 7'h20 && k < 50) begin
            step();
            k++;
        end
        check("t6_tmb_granted", GRANT, 7'h20);
        step();
        #1 pop_rst = 1'b1;
        #1;
        check("t6_rst_grant", GRANT, 0);
        check("t6_rst_busy", BUSY, 0);
        check("t6_rst_rden", RDEN, 0);
        check("t6_rst_done", DONE, 0);
        check("t6_rst_noend", NOEND, 0);
        check("t6_rst_nodata", NODATA, 0);
        @(negedge CLKCMS);
        #1 pop_rst = 1'b0;
        cfg_clear();
        RDY = 7'h7f;
        last_rden[7] = 1;
        last_rden[6] = 1;
        push_g(7'h40, 1); push_g(7'h20, 1);
        push_d('0, '0);
        start_event(7'h60, '0);
        step();
        check("t6_restart_alct", GRANT, 7'h40);
        wait_done(200);

        // 7: START during READ is ignored
        cfg_clear();
        RDY = 7'h02;
        last_rden[2] = 2;
        mid_bit = 7'h02;
        push_g(7'h01, 0); push_g(7'h02, 2);
        push_d('0, 7'h01);
        start_event(7'h03, '0);
        wait_done(300);
        mid_bit = '0;
        repeat (4) step();
        check("t7_nodata_kept", NODATA, 7'h01);

        check("grant_queue_empty", gq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
